// File: rtl/pam_chunk_scan_if.sv
// Handshake and status bundle for the PAM chunk scanner.
// slave = scanner side, master = driver side.
interface pam_chunk_scan_if #(
  parameter int CHUNK_W = 16,
  parameter int PAM_LEN = 3
);
  logic                   start;
  logic [CHUNK_W-1:0]     chunk_len;
  logic [2*PAM_LEN-1:0]   pam_pattern;
  logic [PAM_LEN-1:0]     pam_mask;
  logic                   base_valid;
  logic [1:0]             base_data;
  logic                   base_ready;
  logic                   match_valid;
  logic [CHUNK_W-1:0]     match_pos;
  logic                   match_ready;
  logic                   busy;
  logic                   done;
  logic [CHUNK_W-1:0]     match_count;
  logic [CHUNK_W-1:0]     first_pos;
  logic                   found;

  modport slave (
    input  start, chunk_len, pam_pattern, pam_mask, base_valid, base_data, match_ready,
    output base_ready, match_valid, match_pos, busy, done, match_count, first_pos, found
  );

  modport master (
    output start, chunk_len, pam_pattern, pam_mask, base_valid, base_data, match_ready,
    input  base_ready, match_valid, match_pos, busy, done, match_count, first_pos, found
  );
endinterface

// File: rtl/pam_chunk_scan.sv
// Streams a chunk of 2-bit bases through a sliding window and reports every
// position where the (optionally wildcarded) PAM motif matches.
module pam_chunk_scan #(
  parameter int CHUNK_W = 16,
  parameter int PAM_LEN = 3
) (
  input  logic          ACLK,
  input  logic          ARESETN,
  pam_chunk_scan_if.slave s
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [CHUNK_W-1:0] LP_ONE  = CHUNK_W'(1);
  localparam logic [CHUNK_W-1:0] LP_TAIL = CHUNK_W'(PAM_LEN - 1);

  state_t r_state, w_state_nxt;

  logic [CHUNK_W-1:0]       r_len, r_idx, r_match_pos, r_cnt, r_first_pos;
  logic [PAM_LEN-1:0][1:0]  r_pat, r_win, w_win_nxt;
  logic [PAM_LEN-1:0]       r_mask, w_base_eq;
  logic                     r_match_valid, r_found;
  logic                     w_start_acc, w_base_ready, w_base_acc, w_hit, w_last;

  // A pending match record blocks a new chunk so the record is never orphaned.
  assign w_start_acc  = s.start && (r_state != SEARCH) && !r_match_valid;
  assign w_base_ready = (r_state == SEARCH) && (!r_match_valid || s.match_ready);
  assign w_base_acc   = s.base_valid && w_base_ready;
  assign w_last       = (r_idx == (r_len - LP_ONE));

  // Window index 0 is the oldest base, lining up with pattern bits [1:0].
  always_comb begin
    w_win_nxt = r_win;
    for (int i = 0; i < PAM_LEN - 1; i++) w_win_nxt[i] = r_win[i+1];
    w_win_nxt[PAM_LEN-1] = s.base_data;
  end

  always_comb begin
    w_base_eq = '0;
    for (int i = 0; i < PAM_LEN; i++)
      w_base_eq[i] = r_mask[i] || (w_win_nxt[i] == r_pat[i]);
  end

  assign w_hit = w_base_acc && (r_idx >= LP_TAIL) && (&w_base_eq);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (w_start_acc) w_state_nxt = (s.chunk_len == '0) ? DONE : SEARCH;
      SEARCH:     if (w_base_acc && w_last) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_len         <= '0;
      r_pat         <= '0;
      r_mask        <= '0;
      r_idx         <= '0;
      r_win         <= '0;
      r_match_valid <= 1'b0;
      r_match_pos   <= '0;
      r_cnt         <= '0;
      r_found       <= 1'b0;
      r_first_pos   <= '0;
    end else if (w_start_acc) begin
      r_len       <= s.chunk_len;
      r_pat       <= s.pam_pattern;
      r_mask      <= s.pam_mask;
      r_idx       <= '0;
      r_win       <= '0;
      r_cnt       <= '0;
      r_found     <= 1'b0;
      r_first_pos <= '0;
    end else begin
      if (w_base_acc) begin
        r_win <= w_win_nxt;
        r_idx <= r_idx + LP_ONE;
      end
      // A new hit may overwrite a slot that is being consumed this same cycle.
      if (w_hit) begin
        r_match_valid <= 1'b1;
        r_match_pos   <= r_idx - LP_TAIL;
        if (r_cnt != '1) r_cnt <= r_cnt + LP_ONE;
        if (!r_found) begin
          r_found     <= 1'b1;
          r_first_pos <= r_idx - LP_TAIL;
        end
      end else if (s.match_ready) begin
        r_match_valid <= 1'b0;
      end
    end
  end

  assign s.base_ready  = w_base_ready;
  assign s.match_valid = r_match_valid;
  assign s.match_pos   = r_match_pos;
  assign s.busy        = (r_state == SEARCH);
  assign s.done        = (r_state == DONE) && !r_match_valid;
  assign s.match_count = r_cnt;
  assign s.first_pos   = r_first_pos;
  assign s.found       = r_found;
endmodule

// File: tb/tb_pam_chunk_scan.sv
// Bench for pam_chunk_scan: table of directed chunks, hand-built abort sequence,
// and random chunks checked against a position-list reference model.
module tb_pam_chunk_scan;
  localparam int CW = 16;
  localparam int PL = 3;

  logic ACLK, ARESETN;
  pam_chunk_scan_if #(.CHUNK_W(CW), .PAM_LEN(PL)) bus ();
  pam_chunk_scan #(.CHUNK_W(CW), .PAM_LEN(PL)) dut (.ACLK(ACLK), .ARESETN(ARESETN), .s(bus));

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string      seq;
    logic [5:0] pat;
    logic [2:0] mask;
    int         rmode;   // 0: always ready, 1: random ready, 2: 10-cycle stall at first record
    int         ecnt;
    int         efirst;
  } vec_t;

  logic [1:0] cur_b [0:63];
  bit         hit_at [0:63];
  int         exp_q [$];
  int         m_cnt, m_first;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] b2(byte c);
    case (c)
      "A": return 2'd0;
      "C": return 2'd1;
      "G": return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic load_seq(string s);
    for (int i = 0; i < s.len(); i++) cur_b[i] = b2(s[i]);
  endtask

  // Reference: a window at p matches if every non-wildcard motif base equals base p+i.
  task automatic model(int len, logic [5:0] pat, logic [2:0] mask);
    exp_q.delete();
    m_cnt = 0;
    m_first = 0;
    for (int p = 0; p < 64; p++) hit_at[p] = 1'b0;
    for (int p = 0; p + PL <= len; p++) begin
      bit ok = 1'b1;
      for (int i = 0; i < PL; i++) begin
        logic [5:0] sh = pat >> (2 * i);
        if (!mask[i] && cur_b[p+i] != sh[1:0]) ok = 1'b0;
      end
      if (ok) begin
        hit_at[p] = 1'b1;
        if (m_cnt == 0) m_first = p;
        m_cnt++;
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_bready"}, 32'(bus.base_ready), 0);
    chk({tag, "_mvalid"}, 32'(bus.match_valid), 0);
    chk({tag, "_mpos"}, 32'(bus.match_pos), 0);
    chk({tag, "_mcount"}, 32'(bus.match_count), 0);
    chk({tag, "_first"}, 32'(bus.first_pos), 0);
    chk({tag, "_found"}, 32'(bus.found), 0);
  endtask

  task automatic run_chunk(int len, logic [5:0] pat, logic [2:0] mask, int rmode,
                           int ecnt, int efirst);
    int  sent = 0, mcnt = 0, stall = 0, hit_pos = 0, prev_pos = 0;
    bit  hit_next = 0, prev_hold = 0, stall_used = 0, fin = 0, acc;
    model(len, pat, mask);
    @(negedge ACLK);
    bus.start = 1'b1;
    bus.chunk_len = CW'(len);
    bus.pam_pattern = pat;
    bus.pam_mask = mask;
    bus.base_valid = 1'b0;
    bus.match_ready = 1'b1;
    @(negedge ACLK);
    bus.start = 1'b0;
    bus.chunk_len = CW'($urandom);
    bus.pam_pattern = 6'($urandom);
    bus.pam_mask = 3'($urandom);
    chk("start_clr_count", 32'(bus.match_count), 0);
    chk("start_clr_found", 32'(bus.found), 0);
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (hit_next) begin
        chk("match_latency_valid", 32'(bus.match_valid), 1);
        chk("match_latency_pos", 32'(bus.match_pos), 32'(hit_pos));
        if (rmode == 2 && !stall_used) begin
          stall = 10;
          stall_used = 1'b1;
        end
      end
      if (prev_hold) begin
        chk("hold_valid", 32'(bus.match_valid), 1);
        chk("hold_pos", 32'(bus.match_pos), 32'(prev_pos));
      end
      chk("running_count", 32'(bus.match_count), 32'(mcnt));
      case (rmode)
        0: bus.match_ready = 1'b1;
        1: bus.match_ready = ($urandom_range(0, 3) != 0);
        default: begin
          bus.match_ready = (stall == 0);
          if (stall > 0) stall--;
        end
      endcase
      bus.base_valid = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.base_data = (sent < len) ? cur_b[sent] : 2'($urandom);
      #1;
      if (sent >= len) chk("bready_after_last", 32'(bus.base_ready), 0);
      if (bus.match_valid && !bus.match_ready) chk("bready_slot_full", 32'(bus.base_ready), 0);
      acc = bus.base_valid && bus.base_ready && (sent < len);
      if (bus.match_valid && bus.match_ready) begin
        if (exp_q.size() == 0) chk("extra_match_pos", 32'(bus.match_pos), 32'hFFFF_FFFF);
        else chk("record_pos", 32'(bus.match_pos), 32'(exp_q.pop_front()));
      end
      prev_hold = bus.match_valid && !bus.match_ready;
      prev_pos = int'(bus.match_pos);
      hit_next = 1'b0;
      if (acc) begin
        if (sent >= PL - 1 && hit_at[sent-(PL-1)]) begin
          hit_next = 1'b1;
          hit_pos = sent - (PL - 1);
          mcnt++;
        end
        sent++;
      end
      if (bus.done) begin
        chk("done_all_sent", 32'(sent), 32'(len));
        fin = 1'b1;
      end
      @(negedge ACLK);
    end
    if (!fin) chk("timeout_done", 0, 1);
    bus.base_valid = 1'b0;
    bus.match_ready = 1'b0;
    chk("records_left", 32'(exp_q.size()), 0);
    chk("final_count", 32'(bus.match_count), 32'(ecnt));
    chk("final_found", 32'(bus.found), 32'(ecnt > 0));
    chk("final_first", 32'(bus.first_pos), 32'(efirst));
    chk("final_busy", 32'(bus.busy), 0);
    chk("final_done", 32'(bus.done), 1);
  endtask

  vec_t tbl [9];

  initial begin
    tbl[0] = '{"ACGGTAGG", 6'h28, 3'b001, 0, 2, 1};
    tbl[1] = '{"ACGGTAGG", 6'h28, 3'b001, 2, 2, 1};
    tbl[2] = '{"ACGGTAGG", 6'h28, 3'b001, 1, 2, 1};
    tbl[3] = '{"ACGGTAGG", 6'h0A, 3'b100, 0, 1, 2};
    tbl[4] = '{"ACGGTAGG", 6'h23, 3'b000, 0, 1, 4};
    tbl[5] = '{"GG", 6'h28, 3'b001, 0, 0, 0};
    tbl[6] = '{"AAAAAAAAAAAAAAAA", 6'h28, 3'b001, 0, 0, 0};
    tbl[7] = '{"AGGG", 6'h28, 3'b001, 0, 2, 0};
    tbl[8] = '{"", 6'h28, 3'b001, 0, 0, 0};

    ARESETN = 1'b0;
    bus.start = 1'b0;
    bus.chunk_len = '0;
    bus.pam_pattern = '0;
    bus.pam_mask = '0;
    bus.base_valid = 1'b0;
    bus.base_data = '0;
    bus.match_ready = 1'b0;
    #12;
    check_zero("reset");
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check_zero("idle");

    foreach (tbl[t]) begin
      load_seq(tbl[t].seq);
      run_chunk(tbl[t].seq.len(), tbl[t].pat, tbl[t].mask, tbl[t].rmode,
                tbl[t].ecnt, tbl[t].efirst);
    end

    // Ignored start mid-scan, then asynchronous abort after three bases.
    load_seq("ACGGTAGG");
    @(negedge ACLK);
    bus.start = 1'b1;
    bus.chunk_len = CW'(8);
    bus.pam_pattern = 6'h28;
    bus.pam_mask = 3'b001;
    @(negedge ACLK);
    bus.start = 1'b0;
    bus.match_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.base_valid = 1'b1;
      bus.base_data = cur_b[i];
      bus.start = (i == 1);
      bus.chunk_len = '0;
      @(negedge ACLK);
    end
    bus.start = 1'b0;
    bus.base_valid = 1'b0;
    chk("start_ignored_busy", 32'(bus.busy), 1);
    chk("start_ignored_count", 32'(bus.match_count), 0);
    #2 ARESETN = 1'b0;
    #1 check_zero("abort");
    @(negedge ACLK);
    ARESETN = 1'b1;
    bus.match_ready = 1'b0;
    repeat (2) @(negedge ACLK);
    check_zero("post_abort");
    run_chunk(8, 6'h28, 3'b001, 0, 2, 1);

    for (int r = 0; r < 8; r++) begin
      int         len = $urandom_range(0, 40);
      logic [5:0] pat = 6'($urandom);
      logic [2:0] msk = 3'($urandom);
      for (int i = 0; i < len; i++) cur_b[i] = 2'($urandom_range(0, 3));
      model(len, pat, msk);
      run_chunk(len, pat, msk, 1, m_cnt, m_first);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
